// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
// The state enum, sync word, word width and parity-bit position live here.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] SYNC_WORD  = 8'hA5;
  localparam int         SYNC_W     = 8;
  localparam int         SYNC_CNT_W = $clog2(SYNC_W);
  localparam int         CFG_W      = 36;
  // Position of the parity bit in each word's serial stream (after the data bits).
  localparam int         PARITY_POS = CFG_W;
  localparam int         CNT_W      = 6;

endpackage

// File: rtl/cfg_bitstream_loader_if.sv
// Serial bitstream input and configuration-write output bundle for the loader.
// The master drives the bitstream; the slave (the loader) drives the config write port.
interface cfg_bitstream_loader_if
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_W = 2
);

  logic              start;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [CFG_W-1:0]  cfg_data;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_we;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, cfg_data, cfg_addr, cfg_we, busy, done, err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, cfg_data, cfg_addr, cfg_we, busy, done, err
  );

endinterface

// File: rtl/cfg_word_deserializer.sv
// Collects one LSB-first 36-bit word plus a trailing even-parity bit and
// pulses word_ok or word_bad on the cycle the parity bit is accepted.
module cfg_word_deserializer
  import cfg_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             bit_en_i,
  input  logic             bit_i,
  output logic [CFG_W-1:0] word_o,
  output logic             word_ok_o,
  output logic             word_bad_o
);

  logic [CFG_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             parity_q;
  logic             last_bit;

  assign last_bit   = bit_en_i && (cnt_q == CNT_W'(PARITY_POS));
  assign word_ok_o  = last_bit && (parity_q == bit_i);
  assign word_bad_o = last_bit && (parity_q != bit_i);
  assign word_o     = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is reset along with the control flops so a
    // word cut short by reset can never surface as committed data.
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else if (bit_en_i) begin
      if (last_bit) begin
        cnt_q    <= '0;
        parity_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        shift_q  <= {bit_i, shift_q[CFG_W-1:1]};
        cnt_q    <= cnt_q + CNT_W'(1);
        parity_q <= parity_q ^ bit_i;
      end
    end
  end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Serial configuration loader: checks an 8-bit sync byte, then deserializes
// NUM_BLOCKS parity-protected words and writes each to its routing block.
module cfg_bitstream_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int ADDR_W     = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  cfg_bitstream_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic              bit_ready_q, busy_q, cfg_we_q, done_q, err_q;
  logic [CFG_W-1:0]  cfg_data_q;
  logic [ADDR_W-1:0] cfg_addr_q;
  logic [SYNC_W-2:0] sync_q;
  logic [SYNC_CNT_W-1:0] sync_cnt_q;

  logic             accept, start_go, sync_last, sync_match, last_blk;
  logic [CFG_W-1:0] word;
  logic             word_ok, word_bad;

  assign accept     = bus.bit_valid && bit_ready_q;
  assign start_go   = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign sync_last  = accept && (state_q == ST_SYNC)
                      && (sync_cnt_q == SYNC_CNT_W'(SYNC_W - 1));
  assign sync_match = ({sync_q, bus.bit_in} == SYNC_WORD);
  assign last_blk   = (cfg_addr_q == ADDR_W'(NUM_BLOCKS - 1));

  cfg_word_deserializer u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_go),
    .bit_en_i   (accept && (state_q == ST_LOAD)),
    .bit_i      (bus.bit_in),
    .word_o     (word),
    .word_ok_o  (word_ok),
    .word_bad_o (word_bad)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_go) state_d = ST_SYNC;
      ST_SYNC:  if (sync_last) state_d = sync_match ? ST_LOAD : ST_ERROR;
      ST_LOAD: begin
        if (word_ok)       state_d = ST_WRITE;
        else if (word_bad) state_d = ST_ERROR;
      end
      ST_WRITE: state_d = last_blk ? ST_DONE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_data_q  <= '0;
      cfg_addr_q  <= '0;
      sync_q      <= '0;
      sync_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_ready_q <= (state_d inside {ST_SYNC, ST_LOAD});
      busy_q      <= (state_d inside {ST_SYNC, ST_LOAD, ST_WRITE});
      cfg_we_q    <= (state_d == ST_WRITE);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERROR);

      if (start_go) begin
        sync_cnt_q <= '0;
        cfg_addr_q <= '0;
      end else begin
        if (accept && (state_q == ST_SYNC)) begin
          sync_q     <= {sync_q[SYNC_W-3:0], bus.bit_in};
          sync_cnt_q <= sync_cnt_q + SYNC_CNT_W'(1);
        end
        if ((state_q == ST_WRITE) && !last_blk) cfg_addr_q <= cfg_addr_q + ADDR_W'(1);
      end

      if (word_ok) cfg_data_q <= word;
    end
  end

  assign bus.bit_ready = bit_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_we    = cfg_we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.cfg_addr  = cfg_addr_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader (NUM_BLOCKS=2): a queue of expected
// writes derived from the stream contents is checked against the DUT every cycle.
module tb_cfg_bitstream_loader;

  localparam int NB = 2;
  localparam int AW = 1;

  typedef logic bit_q_t[$];
  typedef struct {
    int          addr;
    logic [35:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  cfg_bitstream_loader_if #(.ADDR_W(AW)) bus ();

  cfg_bitstream_loader #(.NUM_BLOCKS(NB), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  wr_t         wr_log[$];
  wr_t         log_a[$];
  logic [35:0] model_data = '0;
  bit          exp_done, exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every write must match the next expected write, and
  // cfg_data must always equal the last committed word.
  initial begin : compare
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_data = '0;
        continue;
      end
      if (bus.cfg_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", bus.cfg_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", 64'(bus.cfg_addr), 64'(e.addr));
          check("we_data", bus.cfg_data, e.data);
          model_data = e.data;
        end
        wr_log.push_back('{addr: int'(bus.cfg_addr), data: bus.cfg_data});
      end
      check("cfg_data_hold", bus.cfg_data, model_data);
      check("ready_implies_busy", bus.bit_ready & ~bus.busy, 1'b0);
    end
  end

  function automatic bit_q_t make_stream(input logic [7:0] sync, input logic [35:0] w0,
                                         input logic [35:0] w1, input bit bad0);
    bit_q_t      q;
    logic [35:0] w;
    for (int i = 7; i >= 0; i--) q.push_back(sync[i]);
    for (int k = 0; k < NB; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 36; i++) q.push_back(w[i]);
      q.push_back((^w) ^ ((k == 0) && bad0));
    end
    return q;
  endfunction

  task automatic expect_load(input logic [7:0] sync, input logic [35:0] w0,
                             input logic [35:0] w1, input bit bad0);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (sync != 8'hA5 || bad0) begin
      exp_err = 1'b1;
      return;
    end
    exp_q.push_back('{addr: 0, data: w0});
    exp_q.push_back('{addr: 1, data: w1});
    exp_done = 1'b1;
  endtask

  // All drivers run at posedge+1 and return at posedge+1.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap, output bit ok);
    logic rdy;
    ok = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      rdy = bus.bit_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bit_accept_timeout", rdy, 1'b1);
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_bits(input bit_q_t bits, input int max_gap, input int start_at,
                           input int stop_after);
    bit ok;
    for (int i = 0; i < bits.size(); i++) begin
      if (i == stop_after) return;
      if (i == start_at) pulse_start();
      send_bit(bits[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_end(input bit ed, input bit ee);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.done || bus.err) break;
    end
    check("done", bus.done, ed);
    check("err", bus.err, ee);
    check("busy_end", bus.busy, 1'b0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_ready"}, bus.bit_ready, 1'b0);
    check({tag, "_cfg_we"}, bus.cfg_we, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_cfg_data"}, bus.cfg_data, 36'h0);
    check({tag, "_cfg_addr"}, 64'(bus.cfg_addr), 64'd0);
  endtask

  initial begin : stim
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Gap-free two-word load.
    wr_log.delete();
    expect_load(8'hA5, 36'h000000080, 36'h000000040, 1'b0);
    pulse_start();
    send_bits(make_stream(8'hA5, 36'h000000080, 36'h000000040, 1'b0), 0, -1, -1);
    wait_end(exp_done, exp_err);
    log_a = wr_log;
    check("s1_cfg_data", bus.cfg_data, 36'h000000040);
    check("s1_cfg_addr", 64'(bus.cfg_addr), 64'd1);
    check("s1_nwrites", 64'(log_a.size()), 64'd2);
    if (log_a.size() == 2) begin
      check("s1_w0_addr", 64'(log_a[0].addr), 64'd0);
      check("s1_w0_data", log_a[0].data, 36'h000000080);
      check("s1_w1_addr", 64'(log_a[1].addr), 64'd1);
    end

    // Same load with random 0-5 cycle gaps in bit_valid.
    wr_log.delete();
    expect_load(8'hA5, 36'h000000080, 36'h000000040, 1'b0);
    pulse_start();
    send_bits(make_stream(8'hA5, 36'h000000080, 36'h000000040, 1'b0), 5, -1, -1);
    wait_end(exp_done, exp_err);
    check("gap_nwrites", 64'(wr_log.size()), 64'(log_a.size()));
    for (int i = 0; i < wr_log.size() && i < log_a.size(); i++) begin
      check("gap_addr", 64'(wr_log[i].addr), 64'(log_a[i].addr));
      check("gap_data", wr_log[i].data, log_a[i].data);
    end

    // Start pulsed in the middle of LOAD must be ignored.
    expect_load(8'hA5, 36'h9_8765_4321, 36'hF_0000_000F, 1'b0);
    pulse_start();
    send_bits(make_stream(8'hA5, 36'h9_8765_4321, 36'hF_0000_000F, 1'b0), 0, 18, -1);
    wait_end(exp_done, exp_err);
    check("s6_cfg_data", bus.cfg_data, 36'hF_0000_000F);

    // Reset after 20 LOAD bits clears outputs immediately, then a fresh load.
    expect_load(8'hA5, 36'h000000080, 36'h000000040, 1'b0);
    pulse_start();
    send_bits(make_stream(8'hA5, 36'h000000080, 36'h000000040, 1'b0), 0, -1, 28);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    // Start with a simultaneous valid bit in IDLE: that bit must not be consumed.
    wr_log.delete();
    expect_load(8'hA5, 36'h000000080, 36'h000000040, 1'b0);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    send_bits(make_stream(8'hA5, 36'h000000080, 36'h000000040, 1'b0), 0, -1, -1);
    wait_end(exp_done, exp_err);
    if (wr_log.size() > 0) begin
      check("s5_first_addr", 64'(wr_log[0].addr), 64'd0);
      check("s5_first_data", wr_log[0].data, 36'h000000080);
    end else begin
      check("s5_nwrites", 64'(wr_log.size()), 64'd2);
    end

    // Bad sync byte: error right after the 8th bit.
    expect_load(8'hA4, 36'h000000080, 36'h000000040, 1'b0);
    pulse_start();
    send_bits(make_stream(8'hA4, 36'h000000080, 36'h000000040, 1'b0), 0, -1, 8);
    @(negedge clk);
    check("sync_err", bus.err, 1'b1);
    check("sync_bit_ready", bus.bit_ready, 1'b0);
    @(posedge clk); #1;
    wait_end(exp_done, exp_err);
    check("sync_cfg_data_kept", bus.cfg_data, 36'h000000040);

    // Bad parity on the first word after a reset: no write, cfg_data stays 0.
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    expect_load(8'hA5, 36'h000000080, 36'h000000040, 1'b1);
    pulse_start();
    send_bits(make_stream(8'hA5, 36'h000000080, 36'h000000040, 1'b1), 0, -1, 45);
    wait_end(exp_done, exp_err);
    check("par_cfg_data", bus.cfg_data, 36'h0);
    check("par_bit_ready", bus.bit_ready, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_bitstream_loader.md
CFG_BITSTREAM_LOADER -- requirements
Module: cfg_bitstream_loader

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4: number of bidir_routing_block configuration words per load.
REQ-002 SHALL have parameter ADDR_W, default 2: cfg_addr width, at least clog2(NUM_BLOCKS).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle load request.
REQ-006 SHALL have port bit_in  input  1  serial bitstream data.
REQ-007 SHALL have port bit_valid  input  1  bit_in qualifier.
REQ-008 SHALL have port bit_ready  output  1  loader accepts a bit this cycle.
REQ-009 SHALL have port cfg_data  output  36  configuration word for one routing block.
REQ-010 SHALL have port cfg_addr  output  ADDR_W  target block index.
REQ-011 SHALL have port cfg_we  output  1  one-cycle write strobe for cfg_data at cfg_addr.
REQ-012 SHALL have port busy  output  1  high in SYNC, LOAD and WRITE.
REQ-013 SHALL have port done  output  1  load completed.
REQ-014 SHALL have port err  output  1  sync or parity failure.

Function
REQ-015 SHALL accept a bit only on a rising edge where bit_valid and bit_ready are both 1; bit_ready SHALL be 1 only in SYNC and LOAD.
REQ-016 SHALL implement states IDLE, SYNC, LOAD, WRITE, DONE and ERROR.
REQ-017 SHALL leave IDLE, DONE or ERROR for SYNC on start, clear done and err, and set cfg_addr to 0; start SHALL be ignored in SYNC, LOAD and WRITE.
REQ-018 In SYNC, SHALL shift exactly 8 accepted bits, MSB first, and compare them with SYNC_WORD 8'hA5: match -> LOAD; mismatch -> ERROR. There is no sliding search.
REQ-019 In LOAD, SHALL accept 37 bits: 36 data bits, LSB first (bit 0 first), followed by one parity bit.
REQ-020 SHALL check even parity: the XOR of the 36 data bits and the parity bit SHALL equal 0.
REQ-021 On parity pass, SHALL enter WRITE on the cycle after the 37th bit is accepted; on parity fail, SHALL enter ERROR with no cfg_we.
REQ-022 In WRITE, SHALL hold cfg_we at 1 for exactly one cycle with cfg_data and cfg_addr stable.
REQ-023 On leaving WRITE: if cfg_addr == NUM_BLOCKS-1, SHALL go to DONE; otherwise SHALL increment cfg_addr and go to LOAD.
REQ-024 SHALL hold cfg_data at the last written word outside WRITE, and SHALL change it only when a new word is committed.
REQ-025 SHALL hold done=1 in DONE and err=1 in ERROR until the next start or reset.
REQ-026 SHALL use bit and word counters that wrap to 0 at each word boundary; SHALL tolerate gaps in bit_valid of any length without losing state.
REQ-027 SHALL treat simultaneous start and bit_valid in IDLE as the start only; that bit SHALL NOT be consumed.

Reset
REQ-028 While rst_n=0, SHALL force state IDLE, bit_ready, cfg_we, busy, done and err to 0, and cfg_data and cfg_addr to 0, immediately (asynchronously).
REQ-029 SHALL discard a partially loaded word when reset is asserted mid-load, and SHALL issue no cfg_we after reset release until a new start.

Structure
REQ-030 SHALL place the state enum, SYNC_WORD=8'hA5, CFG_W=36 and the parity-bit position in the shared package cfg_loader_pkg.
REQ-031 SHALL implement deserialization and parity accumulation in the sub-module cfg_word_deserializer (36-bit shift register, 6-bit counter, parity flop, word_ok/word_bad pulses).

Verification
REQ-032 SHALL verify: NUM_BLOCKS=2, sync A5, words 36'h000000080 and 36'h000000040 with correct parity -> cfg_we pulses at addr 0 then addr 1 with those words, then done=1.
REQ-033 SHALL verify: sync byte 8'hA4 -> err=1 after the 8th bit, bit_ready=0, and no cfg_we.
REQ-034 SHALL verify: word 36'h000000080 with parity bit 0 -> err=1, no cfg_we, cfg_data remains 0.
REQ-035 SHALL verify: bit_valid toggled randomly with 0–5 cycle gaps -> identical cfg_we and cfg_data sequence to the gap-free run.
REQ-036 SHALL verify: rst_n pulsed low after 20 LOAD bits -> outputs 0 immediately; a new start then loads the first word correctly at addr 0.
REQ-037 SHALL verify: start asserted during LOAD -> ignored, and the load completes normally.
